// File: rtl/serial_word_tx_pkg.sv
// Shared definitions for the serial word transmitter: FSM state encoding and
// default sizing constants also used by the detector benches.
package serial_word_tx_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SHIFT = 2'd1,
    TX_GAP   = 2'd2
  } tx_state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_GAP   = 0;
  localparam int GAP_CNT_W = 8;

endpackage

// File: rtl/serial_word_tx_shreg.sv
// Loadable WIDTH-bit shift register; head is the next bit to be sent, taken
// from the MSB or LSB end depending on MSB_FIRST.
module serial_shreg
  import serial_word_tx_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             head
);

  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] data_next;
  logic [WIDTH-1:0] shifted;

  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted = {data_reg[WIDTH-2:0], 1'b0};
      assign head    = data_reg[WIDTH-1];
    end else begin : g_lsb
      assign shifted = {1'b0, data_reg[WIDTH-1:1]};
      assign head    = data_reg[0];
    end
  endgenerate

  // Load wins over shift so a back-to-back word replaces the spent one.
  always_comb begin
    data_next = data_reg;
    if (load) begin
      data_next = d;
    end else if (shift) begin
      data_next = shifted;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_reg <= '0;
    end else begin
      data_reg <= data_next;
    end
  end

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-to-serial front end: accepts words on valid/ready and streams them
// one bit per clock, with an optional idle gap after each word.
module serial_word_tx
  import serial_word_tx_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP        = DEF_GAP,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = (GAP > 0) ? GAP_CNT_W'(GAP - 1) : '0;

  tx_state_t            state_reg, state_next;
  logic [CNT_W-1:0]     bit_cnt_reg, bit_cnt_next;
  logic [GAP_CNT_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic                 armed_reg;
  logic                 last_bit;
  logic                 accept;
  logic                 load;
  logic                 shift;
  logic                 head;

  serial_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .d     (in_data),
    .head  (head)
  );

  assign last_bit = (state_reg == TX_SHIFT) && (bit_cnt_reg == BIT_LAST);
  // armed_reg keeps in_ready low until the first edge after reset release.
  assign in_ready = armed_reg && ((state_reg == TX_IDLE) || ((GAP == 0) && last_bit));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    gap_cnt_next = gap_cnt_reg;
    load         = 1'b0;
    shift        = 1'b0;
    case (state_reg)
      TX_IDLE: begin
        if (accept) begin
          load         = 1'b1;
          bit_cnt_next = '0;
          state_next   = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        if (bit_cnt_reg == BIT_LAST) begin
          if (GAP > 0) begin
            state_next   = TX_GAP;
            gap_cnt_next = '0;
          end else if (accept) begin
            load         = 1'b1;
            bit_cnt_next = '0;
          end else begin
            state_next = TX_IDLE;
          end
        end else begin
          shift        = 1'b1;
          bit_cnt_next = bit_cnt_reg + 1'b1;
        end
      end
      TX_GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          state_next = TX_IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end
      default: state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= TX_IDLE;
      bit_cnt_reg <= '0;
      gap_cnt_reg <= '0;
      armed_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      gap_cnt_reg <= gap_cnt_next;
      armed_reg   <= 1'b1;
    end
  end

  assign ser_valid = (state_reg == TX_SHIFT);
  assign ser_out   = ser_valid ? head : IDLE_LEVEL;
  assign word_done = last_bit;
  assign busy      = (state_reg != TX_IDLE);

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: three configurations checked cycle by cycle
// against a bit-queue reference model, plus directed word-level checks.
module tb_serial_word_tx;

  logic        clk;
  logic        rst;
  logic [31:0] din;
  logic [2:0]  v;
  logic [2:0]  rdy, so, sv, wd, bz;

  serial_word_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0), .IDLE_LEVEL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_data(din[7:0]), .in_valid(v[0]), .in_ready(rdy[0]),
    .ser_out(so[0]), .ser_valid(sv[0]), .word_done(wd[0]), .busy(bz[0])
  );
  serial_word_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(3), .IDLE_LEVEL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_data(din[7:0]), .in_valid(v[1]), .in_ready(rdy[1]),
    .ser_out(so[1]), .ser_valid(sv[1]), .word_done(wd[1]), .busy(bz[1])
  );
  serial_word_tx #(.WIDTH(2), .MSB_FIRST(1'b1), .GAP(0), .IDLE_LEVEL(1'b0)) dut2 (
    .clk(clk), .rst(rst), .in_data(din[1:0]), .in_valid(v[2]), .in_ready(rdy[2]),
    .ser_out(so[2]), .ser_valid(sv[2]), .word_done(wd[2]), .busy(bz[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // configuration of the instance under test
  int cur, cfg_w, cfg_gap;
  bit cfg_msb, cfg_idle;

  // reference model: bits still to send for the current word, gap cycles left
  bit mq[$];
  int gap_left;
  bit armed;
  bit last_acc;

  bit obs[$];
  int done_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d got=%0h exp=%0h t=%0t", tag, cur, got, exp, $time);
    end
  endtask

  task automatic select(input int inst);
    cur = inst;
    case (inst)
      0:       begin cfg_w = 8; cfg_msb = 1'b1; cfg_gap = 0; cfg_idle = 1'b0; end
      1:       begin cfg_w = 8; cfg_msb = 1'b0; cfg_gap = 3; cfg_idle = 1'b1; end
      default: begin cfg_w = 2; cfg_msb = 1'b1; cfg_gap = 0; cfg_idle = 1'b0; end
    endcase
  endtask

  // One clock cycle: compare outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    bit e_valid, e_out, e_done, e_busy, e_ready;
    e_valid = (mq.size() > 0);
    e_out   = e_valid ? mq[0] : cfg_idle;
    e_done  = (mq.size() == 1);
    e_busy  = e_valid || (gap_left > 0);
    e_ready = armed && (!e_busy || (cfg_gap == 0 && mq.size() == 1));
    @(negedge clk);
    check_eq("ser_valid", sv[cur], e_valid);
    check_eq("ser_out",   so[cur], e_out);
    check_eq("word_done", wd[cur], e_done);
    check_eq("in_ready",  rdy[cur], e_ready);
    check_eq("busy",      bz[cur], e_busy);
    if (sv[cur]) obs.push_back(so[cur]);
    if (wd[cur]) done_cnt++;
    @(posedge clk);
    last_acc = v[cur] && e_ready;
    if (mq.size() > 0) begin
      void'(mq.pop_front());
      if (mq.size() == 0) gap_left = cfg_gap;
    end else if (gap_left > 0) begin
      gap_left--;
    end
    if (last_acc) begin
      for (int i = 0; i < cfg_w; i++)
        mq.push_back(cfg_msb ? din[cfg_w-1-i] : din[i]);
      $display("accept inst=%0d data=%0h t=%0t", cur, din & ((32'd1 << cfg_w) - 1), $time);
    end
    armed = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    v = '0;
    mq.delete();
    gap_left = 0;
    armed = 1'b0;
    #1;
    check_eq("rst_ser_valid", sv[cur], 1'b0);
    check_eq("rst_ser_out",   so[cur], cfg_idle);
    check_eq("rst_word_done", wd[cur], 1'b0);
    check_eq("rst_busy",      bz[cur], 1'b0);
    check_eq("rst_in_ready",  rdy[cur], 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    obs.delete();
    done_cnt = 0;
  endtask

  task automatic send(input logic [31:0] data);
    bit got;
    got = 1'b0;
    din = data;
    v[cur] = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      got = last_acc;
    end
    if (!got) check_eq("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    v[cur] = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_random(input int n);
    bit hold;
    hold = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!hold) begin
        v[cur] = ($urandom_range(0, 99) < 55);
        din = $urandom;
      end
      step();
      hold = v[cur] && !last_acc;
    end
    idle(cfg_w + cfg_gap + 2);
  endtask

  function automatic logic [31:0] pack(input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n && i < obs.size(); i++) r = {r[30:0], obs[i]};
    return r;
  endfunction

  // non-overlapping 1010 detector over the observed bit stream
  function automatic int count_1010();
    logic [3:0] w;
    int c, k;
    w = '0; c = 0; k = 0;
    foreach (obs[i]) begin
      w = {w[2:0], obs[i]};
      k++;
      if (k >= 4 && w == 4'b1010) begin c++; k = 0; end
    end
    return c;
  endfunction

  initial begin
    rst = 1'b0;
    v = '0;
    din = '0;
    done_cnt = 0;
    select(0);

    // 1: single 8'hAA, MSB first
    do_reset();
    step();
    send(32'hAA);
    idle(10);
    check_eq("t1_bits", pack(8), 32'hAA);
    check_eq("t1_nbits", obs.size(), 8);
    check_eq("t1_done", done_cnt, 1);
    check_eq("t1_det", count_1010(), 2);

    // 2: back-to-back with in_valid held
    do_reset();
    step();
    send(32'hF0);
    send(32'h0F);
    idle(10);
    check_eq("t2_bits", pack(16), 32'hF00F);
    check_eq("t2_done", done_cnt, 2);

    // 3: LSB first with a 3-cycle gap and high idle level
    select(1);
    do_reset();
    step();
    send(32'h01);
    idle(14);
    check_eq("t3_bits", pack(8), 32'h80);
    check_eq("t3_nbits", obs.size(), 8);

    // 4: word held off while busy, data changed after acceptance
    select(0);
    do_reset();
    step();
    send(32'h33);
    send(32'h5A);
    din = 32'h00;
    idle(12);
    check_eq("t4_bits", pack(16), 32'h335A);

    // 5: reset mid-word, then a clean word
    do_reset();
    step();
    send(32'hC3);
    v[cur] = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_eq("t5_partial_done", done_cnt, 0);
    do_reset();
    check_eq("t5_abandon_done", done_cnt, 0);
    step();
    send(32'h3C);
    idle(10);
    check_eq("t5_bits", pack(8), 32'h3C);
    check_eq("t5_nbits", obs.size(), 8);

    // 6: 2-bit words, continuous stream
    select(2);
    do_reset();
    step();
    din = 32'h2;
    v[cur] = 1'b1;
    for (int i = 0; i < 20; i++) step();
    idle(4);
    check_eq("t6_bits", pack(16), 32'hAAAA);
    check_eq("t6_nbits", obs.size(), 20);

    // randomized traffic on every configuration
    for (int inst = 0; inst < 3; inst++) begin
      select(inst);
      do_reset();
      step();
      run_random(300);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
